// File: rtl/writeback_forward_pipe_if.sv
// Bus bundle for writeback_forward_pipe: issue lanes, flush, operand
// lookups with forwarding answers, and the two register-file write ports.
interface writeback_forward_pipe_if;
  logic         flush;
  logic         issue_valid_1;
  logic         issue_valid_2;
  logic [6:0]   issue_rt_1;
  logic [6:0]   issue_rt_2;
  logic [127:0] issue_data_1;
  logic [127:0] issue_data_2;
  logic [2:0]   issue_lat_1;
  logic [2:0]   issue_lat_2;
  logic [41:0]  lookup_addr;
  logic [767:0] lookup_data;
  logic [5:0]   lookup_hit;
  logic [5:0]   lookup_stall;
  logic [6:0]   readRegisterRT_WB1;
  logic [6:0]   readRegisterRT_WB2;
  logic [127:0] writeData_WB1;
  logic [127:0] writeData_WB2;
  logic         regWriteEnable_WB1;
  logic         regWriteEnable_WB2;

  // Producer side: execution pipes, register-fetch lookups, register file.
  modport master (
    output flush, issue_valid_1, issue_valid_2, issue_rt_1, issue_rt_2,
           issue_data_1, issue_data_2, issue_lat_1, issue_lat_2, lookup_addr,
    input  lookup_data, lookup_hit, lookup_stall,
           readRegisterRT_WB1, readRegisterRT_WB2, writeData_WB1, writeData_WB2,
           regWriteEnable_WB1, regWriteEnable_WB2
  );

  // The pipe itself.
  modport slave (
    input  flush, issue_valid_1, issue_valid_2, issue_rt_1, issue_rt_2,
           issue_data_1, issue_data_2, issue_lat_1, issue_lat_2, lookup_addr,
    output lookup_data, lookup_hit, lookup_stall,
           readRegisterRT_WB1, readRegisterRT_WB2, writeData_WB1, writeData_WB2,
           regWriteEnable_WB1, regWriteEnable_WB2
  );
endinterface

// File: rtl/writeback_forward_pipe.sv
// Dual-lane result pipeline: ages results through DEPTH stages, retires them
// to the register file from the last stage, and answers six operand lookups
// with forwarded data (youngest match wins) or an advisory stall.
module writeback_forward_pipe #(
  parameter int DEPTH = 4
) (
  input logic                    clk,
  input logic                    reset,
  writeback_forward_pipe_if.slave bus
);

  typedef struct packed {
    logic         valid;
    logic [6:0]   rt;
    logic [127:0] data;
    logic [2:0]   lat;
  } entry_t;

  // Index 0 is lane 1, index 1 is lane 2 (later in program order).
  // Stage index s holds stage number s+1.
  entry_t stage_q [2][DEPTH];
  entry_t stage_d [2][DEPTH];
  logic   we1_q;
  logic   we1_d;

  logic         iss_valid_s [2];
  logic [6:0]   iss_rt_s    [2];
  logic [127:0] iss_data_s  [2];
  logic [2:0]   iss_lat_s   [2];

  logic [5:0]   lookup_hit_s;
  logic [5:0]   lookup_stall_s;
  logic [767:0] lookup_data_s;

  // A unit cannot be faster than one stage nor slower than the pipe itself.
  function automatic logic [2:0] clamp_lat(input logic [2:0] lat);
    if (lat == 3'd0) begin
      clamp_lat = 3'd1;
    end else if (int'(lat) > DEPTH) begin
      clamp_lat = 3'(DEPTH);
    end else begin
      clamp_lat = lat;
    end
  endfunction

  assign iss_valid_s[0] = bus.issue_valid_1;
  assign iss_valid_s[1] = bus.issue_valid_2;
  assign iss_rt_s[0]    = bus.issue_rt_1;
  assign iss_rt_s[1]    = bus.issue_rt_2;
  assign iss_data_s[0]  = bus.issue_data_1;
  assign iss_data_s[1]  = bus.issue_data_2;
  assign iss_lat_s[0]   = bus.issue_lat_1;
  assign iss_lat_s[1]   = bus.issue_lat_2;

  // Next pipe contents: shift every stage down, load stage 1 from issue, and
  // squash all valid bits on flush (issue inputs are ignored that cycle).
  always_comb begin
    stage_d = stage_q;
    for (int l = 0; l < 2; l++) begin
      for (int s = DEPTH - 1; s >= 1; s--) begin
        stage_d[l][s] = stage_q[l][s-1];
        if (bus.flush) begin
          stage_d[l][s].valid = 1'b0;
        end else begin
          stage_d[l][s].valid = stage_q[l][s-1].valid;
        end
      end
      if (bus.flush) begin
        stage_d[l][0].valid = 1'b0;
      end else begin
        stage_d[l][0].valid = iss_valid_s[l];
        stage_d[l][0].rt    = iss_rt_s[l];
        stage_d[l][0].data  = iss_data_s[l];
        stage_d[l][0].lat   = clamp_lat(iss_lat_s[l]);
      end
    end
    // When both lanes retire to the same register, lane 2 is the newer value.
    we1_d = stage_d[0][DEPTH-1].valid &
            ~(stage_d[1][DEPTH-1].valid &
              (stage_d[0][DEPTH-1].rt == stage_d[1][DEPTH-1].rt));
  end

  // Pipe state registers; reset wipes every field so all outputs read zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        for (int s = 0; s < DEPTH; s++) begin
          stage_q[l][s] <= '0;
        end
      end
      we1_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      we1_q   <= we1_d;
    end
  end

  // Operand forwarding: scan oldest to youngest, lane 1 before lane 2, so the
  // last match seen is the youngest stage with lane 2 preferred.
  always_comb begin
    lookup_hit_s   = 6'd0;
    lookup_stall_s = 6'd0;
    lookup_data_s  = 768'd0;
    for (int k = 0; k < 6; k++) begin
      logic         win_found;
      logic         win_ready;
      logic [127:0] win_data;
      logic         match;
      win_found = 1'b0;
      win_ready = 1'b0;
      win_data  = 128'd0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
        for (int l = 0; l < 2; l++) begin
          match = stage_q[l][s].valid &&
                  (stage_q[l][s].rt == bus.lookup_addr[7*k +: 7]);
          win_found = win_found | match;
          win_ready = match ? ((int'(stage_q[l][s].lat) <= s + 1) ? 1'b1 : 1'b0)
                            : win_ready;
          win_data  = match ? stage_q[l][s].data : win_data;
        end
      end
      lookup_hit_s[k]   = win_found & win_ready;
      lookup_stall_s[k] = win_found & ~win_ready;
      lookup_data_s[128*k +: 128] = (win_found & win_ready) ? win_data : 128'd0;
    end
  end

  assign bus.lookup_hit   = lookup_hit_s;
  assign bus.lookup_stall = lookup_stall_s;
  assign bus.lookup_data  = lookup_data_s;

  // Write ports come straight from the last stage registers.
  assign bus.regWriteEnable_WB1 = we1_q;
  assign bus.regWriteEnable_WB2 = stage_q[1][DEPTH-1].valid;
  assign bus.readRegisterRT_WB1 = stage_q[0][DEPTH-1].rt;
  assign bus.readRegisterRT_WB2 = stage_q[1][DEPTH-1].rt;
  assign bus.writeData_WB1      = stage_q[0][DEPTH-1].data;
  assign bus.writeData_WB2      = stage_q[1][DEPTH-1].data;

endmodule

// File: tb/tb_writeback_forward_pipe.sv
// Directed bench for writeback_forward_pipe with DEPTH=4.
module tb_writeback_forward_pipe;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  writeback_forward_pipe_if bus();

  writeback_forward_pipe #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_issue();
    bus.flush         = 1'b0;
    bus.issue_valid_1 = 1'b0;
    bus.issue_valid_2 = 1'b0;
    bus.issue_rt_1    = 7'd0;
    bus.issue_rt_2    = 7'd0;
    bus.issue_data_1  = 128'd0;
    bus.issue_data_2  = 128'd0;
    bus.issue_lat_1   = 3'd0;
    bus.issue_lat_2   = 3'd0;
  endtask

  task automatic issue1(input logic [6:0] rt, input logic [127:0] d, input logic [2:0] lat);
    bus.issue_valid_1 = 1'b1;
    bus.issue_rt_1    = rt;
    bus.issue_data_1  = d;
    bus.issue_lat_1   = lat;
  endtask

  task automatic issue2(input logic [6:0] rt, input logic [127:0] d, input logic [2:0] lat);
    bus.issue_valid_2 = 1'b1;
    bus.issue_rt_2    = rt;
    bus.issue_data_2  = d;
    bus.issue_lat_2   = lat;
  endtask

  task automatic drain();
    clear_issue();
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_reset();
    issue1(7'd3, 128'd33, 3'd1);
    issue2(7'd4, 128'd44, 3'd1);
    tick();
    clear_issue();
    tick(); tick(); tick();
    bus.lookup_addr = {6{7'd3}};
    #1;
    checks++;
    if ({bus.regWriteEnable_WB1, bus.regWriteEnable_WB2} !== 2'b11) begin
      failures++;
      $display("FAIL reset_pre_we actual=%b expected=11", {bus.regWriteEnable_WB1, bus.regWriteEnable_WB2});
    end
    checks++;
    if (bus.lookup_hit !== 6'h3F) begin
      failures++;
      $display("FAIL reset_pre_hit actual=%h expected=3f", bus.lookup_hit);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.regWriteEnable_WB1, bus.regWriteEnable_WB2, bus.lookup_hit, bus.lookup_stall} !== 14'd0) begin
      failures++;
      $display("FAIL reset_async_flags actual=%b expected=0",
               {bus.regWriteEnable_WB1, bus.regWriteEnable_WB2, bus.lookup_hit, bus.lookup_stall});
    end
    checks++;
    if ({bus.readRegisterRT_WB1, bus.readRegisterRT_WB2, bus.writeData_WB1, bus.writeData_WB2} !== 270'd0) begin
      failures++;
      $display("FAIL reset_async_wb actual rt1=%0d rt2=%0d d1=%0h d2=%0h expected=0",
               bus.readRegisterRT_WB1, bus.readRegisterRT_WB2, bus.writeData_WB1, bus.writeData_WB2);
    end
    checks++;
    if (bus.lookup_data !== 768'd0) begin
      failures++;
      $display("FAIL reset_async_data actual=%0h expected=0", bus.lookup_data);
    end
    #2 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus.regWriteEnable_WB1, bus.regWriteEnable_WB2, bus.lookup_hit, bus.lookup_stall,
           bus.readRegisterRT_WB1, bus.readRegisterRT_WB2, bus.writeData_WB1, bus.writeData_WB2} !== 284'd0
          || bus.lookup_data !== 768'd0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d actual we=%b hit=%h stall=%h expected all zero",
                 i, {bus.regWriteEnable_WB1, bus.regWriteEnable_WB2}, bus.lookup_hit, bus.lookup_stall);
      end
    end
  endtask

  task automatic test_single_retire();
    logic [5:0] exp_hit   [5] = '{6'h00, 6'h3F, 6'h3F, 6'h3F, 6'h00};
    logic [5:0] exp_stall [5] = '{6'h3F, 6'h00, 6'h00, 6'h00, 6'h00};
    logic       exp_we1   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [127:0] exp_d;
    bus.lookup_addr = {6{7'd5}};
    issue1(7'd5, 128'd5300, 3'd2);
    for (int e = 0; e < 5; e++) begin
      tick();
      clear_issue();
      exp_d = (exp_hit[e] != 6'h00) ? 128'd5300 : 128'd0;
      checks++;
      if (bus.lookup_hit !== exp_hit[e] || bus.lookup_stall !== exp_stall[e]) begin
        failures++;
        $display("FAIL single_lookup edge=%0d actual hit=%h stall=%h expected hit=%h stall=%h",
                 e, bus.lookup_hit, bus.lookup_stall, exp_hit[e], exp_stall[e]);
      end
      checks++;
      if (bus.lookup_data[128*3 +: 128] !== exp_d) begin
        failures++;
        $display("FAIL single_data edge=%0d actual=%0d expected=%0d", e, bus.lookup_data[128*3 +: 128], exp_d);
      end
      checks++;
      if (bus.regWriteEnable_WB1 !== exp_we1[e] || bus.regWriteEnable_WB2 !== 1'b0) begin
        failures++;
        $display("FAIL single_we edge=%0d actual we1=%b we2=%b expected we1=%b we2=0",
                 e, bus.regWriteEnable_WB1, bus.regWriteEnable_WB2, exp_we1[e]);
      end
      if (e == 3) begin
        checks++;
        if (bus.readRegisterRT_WB1 !== 7'd5 || bus.writeData_WB1 !== 128'd5300) begin
          failures++;
          $display("FAIL single_wb actual rt=%0d data=%0d expected rt=5 data=5300",
                   bus.readRegisterRT_WB1, bus.writeData_WB1);
        end
      end
    end
    drain();
  endtask

  task automatic test_youngest_wins();
    logic [5:0]   exp_hit   [6] = '{6'h3F, 6'h00, 6'h00, 6'h3F, 6'h3F, 6'h00};
    logic [5:0]   exp_stall [6] = '{6'h00, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
    logic [127:0] exp_d     [6] = '{128'd1, 128'd0, 128'd0, 128'd2, 128'd2, 128'd0};
    bus.lookup_addr = {6{7'd7}};
    issue1(7'd7, 128'd1, 3'd1);
    for (int e = 0; e < 6; e++) begin
      tick();
      clear_issue();
      if (e == 0) issue1(7'd7, 128'd2, 3'd3);
      checks++;
      if (bus.lookup_hit !== exp_hit[e] || bus.lookup_stall !== exp_stall[e]
          || bus.lookup_data[0 +: 128] !== exp_d[e]) begin
        failures++;
        $display("FAIL youngest edge=%0d actual hit=%h stall=%h data=%0d expected hit=%h stall=%h data=%0d",
                 e, bus.lookup_hit, bus.lookup_stall, bus.lookup_data[0 +: 128],
                 exp_hit[e], exp_stall[e], exp_d[e]);
      end
    end
    drain();
  endtask

  task automatic test_same_stage();
    bus.lookup_addr = {6{7'd9}};
    issue1(7'd9, 128'd10, 3'd1);
    issue2(7'd9, 128'd20, 3'd1);
    for (int e = 0; e < 5; e++) begin
      tick();
      clear_issue();
      if (e < 4) begin
        checks++;
        if (bus.lookup_hit !== 6'h3F || bus.lookup_data[128*5 +: 128] !== 128'd20) begin
          failures++;
          $display("FAIL same_stage_lookup edge=%0d actual hit=%h data=%0d expected hit=3f data=20",
                   e, bus.lookup_hit, bus.lookup_data[128*5 +: 128]);
        end
      end
      checks++;
      if (bus.regWriteEnable_WB1 !== 1'b0 || bus.regWriteEnable_WB2 !== (e == 3)) begin
        failures++;
        $display("FAIL same_stage_we edge=%0d actual we1=%b we2=%b expected we1=0 we2=%b",
                 e, bus.regWriteEnable_WB1, bus.regWriteEnable_WB2, (e == 3));
      end
      if (e == 3) begin
        checks++;
        if (bus.readRegisterRT_WB2 !== 7'd9 || bus.writeData_WB2 !== 128'd20) begin
          failures++;
          $display("FAIL same_stage_wb2 actual rt=%0d data=%0d expected rt=9 data=20",
                   bus.readRegisterRT_WB2, bus.writeData_WB2);
        end
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bus.lookup_addr = {7'd14, 7'd14, 7'd14, 7'd13, 7'd12, 7'd11};
    issue1(7'd11, 128'hAA, 3'd1);
    issue2(7'd12, 128'hBB, 3'd2);
    tick();
    clear_issue();
    issue1(7'd13, 128'hCC, 3'd4);
    tick();
    clear_issue();
    tick(); tick();
    checks++;
    if ({bus.regWriteEnable_WB1, bus.regWriteEnable_WB2} !== 2'b11
        || bus.readRegisterRT_WB1 !== 7'd11 || bus.writeData_WB1 !== 128'hAA
        || bus.readRegisterRT_WB2 !== 7'd12 || bus.writeData_WB2 !== 128'hBB) begin
      failures++;
      $display("FAIL b2b_dual_wb actual we=%b rt1=%0d d1=%0h rt2=%0d d2=%0h expected we=11 rt1=11 d1=aa rt2=12 d2=bb",
               {bus.regWriteEnable_WB1, bus.regWriteEnable_WB2}, bus.readRegisterRT_WB1,
               bus.writeData_WB1, bus.readRegisterRT_WB2, bus.writeData_WB2);
    end
    checks++;
    if (bus.lookup_hit !== 6'b000011 || bus.lookup_stall !== 6'b000100) begin
      failures++;
      $display("FAIL b2b_ports actual hit=%b stall=%b expected hit=000011 stall=000100",
               bus.lookup_hit, bus.lookup_stall);
    end
    checks++;
    if (bus.lookup_data[0 +: 128] !== 128'hAA || bus.lookup_data[128 +: 128] !== 128'hBB
        || bus.lookup_data[256 +: 128] !== 128'd0) begin
      failures++;
      $display("FAIL b2b_data actual p0=%0h p1=%0h p2=%0h expected p0=aa p1=bb p2=0",
               bus.lookup_data[0 +: 128], bus.lookup_data[128 +: 128], bus.lookup_data[256 +: 128]);
    end
    tick();
    checks++;
    if ({bus.regWriteEnable_WB1, bus.regWriteEnable_WB2} !== 2'b10
        || bus.readRegisterRT_WB1 !== 7'd13 || bus.writeData_WB1 !== 128'hCC
        || bus.lookup_hit !== 6'b000100) begin
      failures++;
      $display("FAIL b2b_second actual we=%b rt1=%0d d1=%0h hit=%b expected we=10 rt1=13 d1=cc hit=000100",
               {bus.regWriteEnable_WB1, bus.regWriteEnable_WB2}, bus.readRegisterRT_WB1,
               bus.writeData_WB1, bus.lookup_hit);
    end
    drain();
  endtask

  task automatic test_flush();
    bus.lookup_addr = {7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1};
    for (int e = 0; e < 4; e++) begin
      issue1(7'(e + 1), 128'(100 + e + 1), 3'd1);
      tick();
      clear_issue();
    end
    checks++;
    if (bus.regWriteEnable_WB1 !== 1'b1 || bus.readRegisterRT_WB1 !== 7'd1 || bus.writeData_WB1 !== 128'd101) begin
      failures++;
      $display("FAIL flush_pre_wb actual we1=%b rt=%0d data=%0d expected we1=1 rt=1 data=101",
               bus.regWriteEnable_WB1, bus.readRegisterRT_WB1, bus.writeData_WB1);
    end
    checks++;
    if (bus.lookup_hit !== 6'b001111) begin
      failures++;
      $display("FAIL flush_pre_hit actual=%b expected=001111", bus.lookup_hit);
    end
    bus.flush = 1'b1;
    issue1(7'd5, 128'd105, 3'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      clear_issue();
      checks++;
      if ({bus.regWriteEnable_WB1, bus.regWriteEnable_WB2} !== 2'b00
          || bus.lookup_hit !== 6'd0 || bus.lookup_stall !== 6'd0) begin
        failures++;
        $display("FAIL flush_after cycle=%0d actual we=%b hit=%b stall=%b expected all zero",
                 i, {bus.regWriteEnable_WB1, bus.regWriteEnable_WB2}, bus.lookup_hit, bus.lookup_stall);
      end
    end
    drain();
  endtask

  task automatic test_latency_clamp();
    bus.lookup_addr = {7'd22, 7'd22, 7'd22, 7'd22, 7'd21, 7'd20};
    issue1(7'd20, 128'd32, 3'd0);
    issue2(7'd21, 128'd33, 3'd7);
    for (int e = 0; e < 4; e++) begin
      tick();
      clear_issue();
      checks++;
      if (e < 3) begin
        if (bus.lookup_hit !== 6'b000001 || bus.lookup_stall !== 6'b000010
            || bus.lookup_data[0 +: 128] !== 128'd32 || bus.lookup_data[128 +: 128] !== 128'd0) begin
          failures++;
          $display("FAIL clamp_early edge=%0d actual hit=%b stall=%b p0=%0d p1=%0d expected hit=000001 stall=000010 p0=32 p1=0",
                   e, bus.lookup_hit, bus.lookup_stall, bus.lookup_data[0 +: 128], bus.lookup_data[128 +: 128]);
        end
      end else begin
        if (bus.lookup_hit !== 6'b000011 || bus.lookup_stall !== 6'b000000
            || bus.lookup_data[128 +: 128] !== 128'd33) begin
          failures++;
          $display("FAIL clamp_stage4 actual hit=%b stall=%b p1=%0d expected hit=000011 stall=000000 p1=33",
                   bus.lookup_hit, bus.lookup_stall, bus.lookup_data[128 +: 128]);
        end
      end
    end
    drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear_issue();
    bus.lookup_addr = 42'd0;
    tick(); tick();
    #2 reset = 1'b0;
    tick();
    test_reset();
    test_single_retire();
    test_youngest_wins();
    test_same_stage();
    test_back_to_back();
    test_flush();
    test_latency_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_forward_pipe.md
# writeback_forward_pipe

Dual-issue result pipeline that drives the write ports of `RegisterFetchStage`. It accepts one result per lane per cycle from the even and odd execution pipes, ages each result through `DEPTH` registered stages, and retires it on `regWriteEnable_WB1/2`. While results are in flight, it answers the six register-fetch operand lookups with forwarded data, or with a stall when the newest matching result is not yet ready.

## Interface
- `DEPTH`, 4: number of pipeline stages; write-back occurs from stage `DEPTH`.
- `clk` input 1: sole clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all stage valid bits.
- `flush` input 1: synchronous; discards all in-flight and issuing results.
- `issue_valid_1` / `issue_valid_2` input 1: a result is issued on lane 1 / lane 2 (lane 2 is later in program order).
- `issue_rt_1` / `issue_rt_2` input 7: destination register.
- `issue_data_1` / `issue_data_2` input 128: result value.
- `issue_lat_1` / `issue_lat_2` input 3: unit latency in stages.
- `lookup_addr` input 42: six 7-bit read addresses, index k = bits [7k+6:7k], ordered RA1, RA2, RB1, RB2, RC1, RC2.
- `lookup_data` output 768: forwarded value per lookup, index k = bits [128k+127:128k].
- `lookup_hit` output 6: bit k is 1 when `lookup_data` k is valid forwarded data.
- `lookup_stall` output 6: bit k is 1 when lookup k matches an in-flight result that is not yet ready.
- `readRegisterRT_WB1` / `readRegisterRT_WB2` output 7: write address to the register file.
- `writeData_WB1` / `writeData_WB2` output 128: write data.
- `regWriteEnable_WB1` / `regWriteEnable_WB2` output 1: write strobes.

## Operation
- Each lane has stages 1..`DEPTH`. Each stage entry holds {valid, rt, data, lat}.
- On each edge, stage s moves to stage s+1. The issue inputs load stage 1, with valid = `issue_valid_n`.
- Latency clamp at issue: `lat` 0 becomes 1; `lat` greater than `DEPTH` becomes `DEPTH`.
- An entry at stage s is ready when s >= lat.
- The write-back outputs are stage `DEPTH` of each lane, driven directly from registers. `regWriteEnable_WBn` equals that stage's valid bit.
- Same-target retirement: if both stage-`DEPTH` entries are valid with equal rt, `regWriteEnable_WB1` is forced to 0, so lane 2 wins.
- Lookup is combinational, per port k:
  - Candidates are all valid entries with rt == addr k.
  - Priority: the lowest stage index (youngest) wins. Within the same stage, lane 2 beats lane 1.
  - If the winner is ready: hit=1, data=winner data, stall=0.
  - If the winner is not ready: hit=0, stall=1, data=0.
  - If there is no candidate: hit=0, stall=0, data=0.
- Entries in stage `DEPTH` take part in lookup. The register file reads before it writes within the same evaluation, so forwarding covers that cycle.
- `flush`: on the edge, all valid bits clear and the issue inputs are ignored. The entries already presented at stage `DEPTH` in the flush cycle are still written, because their outputs were visible before the edge.
- `reset` has priority over `flush` and issue.

## Timing
- Reset values:
  - All valid bits are 0.
  - All `regWriteEnable_WB*`, `lookup_hit`, and `lookup_stall` are 0.
  - `readRegisterRT_WB*` and `writeData_WB*` are 0.
  - `lookup_data` is 0.
- Asserting `reset` mid-operation clears outputs immediately, without waiting for `clk`. In-flight results are lost.
- An issue sampled at edge t appears on the write-back outputs after edge t+`DEPTH`-1, i.e. `DEPTH` cycles of residency in total.
- A result with latency L issued at edge t becomes forwardable (hit) after edge t+L-1. Before that, a matching lookup stalls.
- Throughput is two results per cycle with no backpressure. Issue is never refused.
- Stall is advisory only; this block does not freeze itself.

## Test plan
- Reset and idle:
  - Stimulus: assert `reset` asynchronously between edges, then hold all issue valids at 0.
  - Required response: all outputs 0 immediately, and for 10 cycles.
- Single retire, `DEPTH`=4:
  - Stimulus: lane 1 issues rt=5, data=5300, lat=2 at edge 0.
  - Required response, lookup rt=5 per edge:
    - Stall=1 after edge 0.
    - Hit=1, data=5300 after edge 1.
    - After edge 3: `regWriteEnable_WB1`=1, `readRegisterRT_WB1`=5, `writeData_WB1`=5300 for exactly one cycle.
- Youngest-wins forwarding:
  - Stimulus: rt=7 data=1 lat=1 at edge 0; rt=7 data=2 lat=3 at edge 1.
  - Required response: after edge 1, lookup rt=7 gives stall=1, hit=0 (the younger result is not ready). After edge 3, hit=1, data=2.
- Same-stage lane priority and same-target retire:
  - Stimulus: both lanes issue rt=9 in the same cycle, data 10 (lane 1) and 20 (lane 2), lat=1.
  - Required response: lookup rt=9 returns 20. At retire, `regWriteEnable_WB1`=0 and `regWriteEnable_WB2`=1 with data 20.
- Flush:
  - Stimulus: issue on 4 consecutive edges (rt 1..4), then assert `flush` on the next edge.
  - Required response: the rt=1 write, presented before the flush edge, occurs. Afterwards no further writes occur, and all lookups show hit=0, stall=0.
- Latency clamp:
  - Stimulus: issue `lat`=0 and `lat`=7 with `DEPTH`=4.
  - Required response: the `lat`=0 result is forwardable after its issue edge. The `lat`=7 result is forwardable only when it reaches stage 4.
